sdram_refresh_arbiter: RTL

SDRAM_REFRESH_ARBITER -- requirements
Module: sdram_refresh_arbiter

---
 rtl/sdram_refresh_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sdram_refresh_arbiter.sv
// sdram_refresh_arbiter: SDRAM power-up init sequencer plus refresh/user arbiter for the command bus
// Ports: CLOCK_50 clock, resetN async active-low reset
//        user_req/user_gnt bus request and grant; user_cmd/user_addr/user_ba forwarded while granted
//        ref_urgent refresh debt at or above 4; init_done init sequence complete
//        sdram_cmd/sdram_addr/sdram_ba/sdram_cke registered SDRAM command bus
module sdram_refresh_arbiter #(
    parameter int          INIT_CYCLES  = 10000,
    parameter int          REF_INTERVAL = 390,
    parameter int          T_RP         = 2,
    parameter int          T_RFC        = 4,
    parameter int          T_MRD        = 2,
    parameter logic [12:0] MODE_REG     = 13'h0020
) (
    input  logic        CLOCK_50,
    input  logic        resetN,
    input  logic        user_req,
    output logic        user_gnt,
    input  logic [3:0]  user_cmd,
    input  logic [12:0] user_addr,
    input  logic [1:0]  user_ba,
    output logic        ref_urgent,
    output logic        init_done,
    output logic [3:0]  sdram_cmd,
    output logic [12:0] sdram_addr,
    output logic [1:0]  sdram_ba,
    output logic        sdram_cke
);
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_REF = 4'b0001;
    localparam logic [3:0] CMD_LMR = 4'b0000;
    localparam int CW = $clog2(INIT_CYCLES + T_RP + T_RFC + T_MRD + 2);
    localparam int TW = $clog2(REF_INTERVAL + 1);
    typedef enum logic [2:0] {INIT_WAIT, INIT_PRE, INIT_REF, INIT_MRS, IDLE, GRANT, REF} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic [3:0]    debt, debt_nx;
    logic          second_ref, tick, dec;
    // Each command state counts its NOP cycles in cnt; cnt reaching the T_* value issues the next command.
    always_comb begin
        tick    = init_done && timer == TW'(REF_INTERVAL - 1);
        dec     = state == REF && cnt == CW'(T_RFC);
        debt_nx = (tick && !dec && debt != 4'd8) ? debt + 4'd1 : (dec && !tick) ? debt - 4'd1 : debt;
    end
    always_ff @(posedge CLOCK_50 or negedge resetN) begin
        if (!resetN) begin
            state      <= INIT_WAIT;
            cnt        <= '0;
            timer      <= '0;
            debt       <= '0;
            second_ref <= 1'b0;
            user_gnt   <= 1'b0;
            init_done  <= 1'b0;
            ref_urgent <= 1'b0;
            sdram_cmd  <= CMD_NOP;
            sdram_addr <= '0;
            sdram_ba   <= '0;
            sdram_cke  <= 1'b0;
        end else begin
            sdram_cke  <= 1'b1;
            sdram_cmd  <= CMD_NOP;
            sdram_addr <= '0;
            sdram_ba   <= '0;
            cnt        <= cnt + CW'(1);
            debt       <= debt_nx;
            ref_urgent <= debt_nx >= 4'd4;
            if (init_done)
                timer <= tick ? '0 : timer + TW'(1);
            case (state)
                INIT_WAIT: if (cnt == CW'(INIT_CYCLES)) begin
                    state      <= INIT_PRE;
                    cnt        <= '0;
                    sdram_cmd  <= CMD_PRE;
                    sdram_addr <= 13'h0400;
                end
                INIT_PRE: if (cnt == CW'(T_RP)) begin
                    state      <= INIT_REF;
                    cnt        <= '0;
                    second_ref <= 1'b0;
                    sdram_cmd  <= CMD_REF;
                end
                INIT_REF: if (cnt == CW'(T_RFC)) begin
                    cnt <= '0;
                    if (!second_ref) begin
                        second_ref <= 1'b1;
                        sdram_cmd  <= CMD_REF;
                    end else begin
                        state      <= INIT_MRS;
                        sdram_cmd  <= CMD_LMR;
                        sdram_addr <= MODE_REG;
                    end
                end
                INIT_MRS: if (cnt == CW'(T_MRD)) begin
                    state     <= IDLE;
                    init_done <= 1'b1;
                end
                GRANT: if (user_req) begin
                    sdram_cmd  <= user_cmd;
                    sdram_addr <= user_addr;
                    sdram_ba   <= user_ba;
                end else begin
                    state    <= IDLE;
                    user_gnt <= 1'b0;
                end
                // The end of a refresh arbitrates directly so owed refreshes run back to back.
                IDLE, REF: if (state == IDLE || dec) begin
                    if (debt_nx != 4'd0) begin
                        state     <= REF;
                        cnt       <= '0;
                        sdram_cmd <= CMD_REF;
                    end else if (user_req) begin
                        state    <= GRANT;
                        user_gnt <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= INIT_WAIT;
            endcase
        end
    end
endmodule
